// File: rtl/waterfall_pkg.sv
// Shared waterfall constants and write-controller state type.
// The display-side coordinate mapper imports the same package.
package waterfall_pkg;

  localparam int unsigned NO_FFTS        = 50;
  localparam int unsigned NO_BANKS       = 2;
  localparam int unsigned RAM_ADDR_WIDTH = 12;
  localparam int unsigned IDX_WIDTH      = $clog2(NO_FFTS);

  typedef enum logic [0:0] {
    S_FILL,
    S_HOLD
  } state_e;

endpackage

// File: rtl/waterfall_write_ctrl_slot_addr_map.sv
// Ring slot + bin -> one-hot bank and per-bank address.
// The display-side reader uses the same block, so both sides agree on the layout.
module slot_addr_map #(
  parameter int unsigned NO_FFTS        = 50,
  parameter int unsigned LINE           = 128,
  parameter int unsigned IDX_WIDTH      = 6,
  parameter int unsigned BIN_WIDTH      = 8,
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 12
) (
  input  logic [IDX_WIDTH-1:0]      slot,
  input  logic [BIN_WIDTH-1:0]      bin,
  output logic [NO_BANKS-1:0]       bank,
  output logic [RAM_ADDR_WIDTH-1:0] addr
);

  localparam int unsigned Half = NO_FFTS / 2;

  logic        upper;
  logic [31:0] row;

  // Slots 0..Half-1 live in bank 0, the rest in bank 1 at the same row offsets.
  always_comb begin
    upper = 32'(slot) >= Half;
    row   = upper ? 32'(slot) - Half : 32'(slot);
    bank  = upper ? NO_BANKS'(2) : NO_BANKS'(1);
    addr  = RAM_ADDR_WIDTH'(row * LINE + 32'(bin));
  end

endmodule

// File: rtl/waterfall_write_ctrl.sv
// Writes the positive-frequency half of each FFT line into the waterfall ring and
// advances the oldest-line index only on a display frame boundary.
module waterfall_write_ctrl #(
  parameter int unsigned FFT_SIZE       = 256,
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned NO_FFTS        = waterfall_pkg::NO_FFTS,
  parameter int unsigned NO_BANKS       = waterfall_pkg::NO_BANKS,
  parameter int unsigned RAM_ADDR_WIDTH = waterfall_pkg::RAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_last,
  input  logic                       frame_start,
  output logic [NO_BANKS-1:0]        wr_bank,
  output logic [RAM_ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx,
  output logic                       line_done,
  output logic                       sync_err
);

  import waterfall_pkg::*;

  localparam int unsigned BinW = $clog2(FFT_SIZE);
  localparam int unsigned IdxW = $clog2(NO_FFTS);
  localparam int unsigned Line = FFT_SIZE / 2;

  state_e                    state_q, state_d;
  logic [BinW-1:0]           bin_q, bin_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [NO_BANKS-1:0]       wr_bank_q, wr_bank_d;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      line_done_q, line_done_d;
  logic                      sync_err_q, sync_err_d;

  logic [NO_BANKS-1:0]       map_bank;
  logic [RAM_ADDR_WIDTH-1:0] map_addr;
  logic                      accept, keep, at_end;

  slot_addr_map #(
    .NO_FFTS        (NO_FFTS),
    .LINE           (Line),
    .IDX_WIDTH      (IdxW),
    .BIN_WIDTH      (BinW),
    .NO_BANKS       (NO_BANKS),
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_slot_addr_map (
    .slot (idx_q),
    .bin  (bin_q),
    .bank (map_bank),
    .addr (map_addr)
  );

  assign s_ready = (state_q == S_FILL) && !reset;
  assign accept  = s_valid && s_ready;
  assign keep    = 32'(bin_q) < Line;
  assign at_end  = 32'(bin_q) == FFT_SIZE - 1;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    idx_d       = idx_q;
    wr_bank_d   = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_done_d = 1'b0;
    sync_err_d  = sync_err_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          if (keep) begin
            wr_bank_d = map_bank;
            wr_addr_d = map_addr;
            wr_data_d = s_data;
          end
          if (at_end) begin
            // A full-length line counts even if s_last is missing.
            state_d     = S_HOLD;
            bin_d       = '0;
            line_done_d = 1'b1;
            if (!s_last) sync_err_d = 1'b1;
          end else if (s_last) begin
            // Short line: resync on the next beat, same slot, no advance.
            sync_err_d = 1'b1;
            bin_d      = '0;
          end else begin
            bin_d = bin_q + BinW'(1);
          end
        end
      end
      S_HOLD: begin
        if (frame_start) begin
          idx_d   = (32'(idx_q) == NO_FFTS - 1) ? '0 : idx_q + IdxW'(1);
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      bin_q       <= '0;
      idx_q       <= '0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      idx_q       <= idx_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign wr_bank        = wr_bank_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign oldest_fft_idx = idx_q;
  assign line_done      = line_done_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_waterfall_write_ctrl.sv
// Scoreboard bench for waterfall_write_ctrl at default parameters.
module tb_waterfall_write_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        frame_start = 1'b0;
  logic [1:0]  wr_bank;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        line_done;
  logic        sync_err;

  always #5 clk = ~clk;

  waterfall_write_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .frame_start    (frame_start),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .line_done      (line_done),
    .sync_err       (sync_err)
  );

  typedef struct packed {
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;
  int  ld_seen = 0;
  bit  mon_en = 1'b0;

  // Reference model of the controller, advanced at each driven cycle.
  bit  m_hold = 1'b0;
  int  m_bin = 0;
  int  m_slot = 0;
  bit  m_err = 1'b0;
  bit  m_ld = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (line_done === 1'b1) ld_seen++;
      n_cmp++;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (wr_bank !== mon_e.bank || wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          n_err++;
          $display("FAIL write: got bank=%b addr=%0d data=%h, want bank=%b addr=%0d data=%h",
                   wr_bank, wr_addr, wr_data, mon_e.bank, mon_e.addr, mon_e.data);
        end
      end else if (wr_bank !== 2'b00) begin
        n_err++;
        $display("FAIL idle_write: got bank=%b addr=%0d, want bank=00", wr_bank, wr_addr);
      end
      n_cmp++;
      if (line_done !== m_ld) begin
        n_err++;
        $display("FAIL line_done: got %b want %b at %0t", line_done, m_ld, $time);
      end
      n_cmp++;
      if (oldest_fft_idx !== 6'(m_slot)) begin
        n_err++;
        $display("FAIL oldest_idx: got %0d want %0d at %0t", oldest_fft_idx, m_slot, $time);
      end
      n_cmp++;
      if (sync_err !== m_err) begin
        n_err++;
        $display("FAIL sync_err: got %b want %b at %0t", sync_err, m_err, $time);
      end
    end
  end

  task automatic cycle(input bit v, input logic [3:0] d, input bit l, input bit fs);
    logic [1:0]  eb;
    logic [11:0] ea;
    @(negedge clk);
    reset = 1'b0;
    s_valid = v;
    s_data = d;
    s_last = l;
    frame_start = fs;
    #1;
    n_cmp++;
    if (s_ready !== !m_hold) begin
      n_err++;
      $display("FAIL s_ready: got %b want %b at %0t", s_ready, !m_hold, $time);
    end
    m_ld = 1'b0;
    if (!m_hold) begin
      if (v) begin
        if (m_bin < 128) begin
          eb = (m_slot >= 25) ? 2'b10 : 2'b01;
          ea = 12'((m_slot % 25) * 128 + m_bin);
          exp_q.push_back(wr_t'{bank: eb, addr: ea, data: d});
        end
        if (m_bin == 255) begin
          if (!l) m_err = 1'b1;
          m_hold = 1'b1;
          m_bin = 0;
          m_ld = 1'b1;
        end else if (l) begin
          m_err = 1'b1;
          m_bin = 0;
        end else begin
          m_bin++;
        end
      end
    end else if (fs) begin
      m_slot = (m_slot == 49) ? 0 : m_slot + 1;
      m_hold = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    frame_start = 1'b0;
    m_hold = 1'b0;
    m_bin = 0;
    m_slot = 0;
    m_err = 1'b0;
    m_ld = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_in_reset: got %b want 0", s_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_bank, wr_addr, wr_data, line_done, oldest_fft_idx, sync_err} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got bank=%b addr=%0d data=%h ld=%b idx=%0d err=%b want all 0",
               wr_bank, wr_addr, wr_data, line_done, oldest_fft_idx, sync_err);
    end
  endtask

  task automatic send_line(input int n, input int last_at, input int fs_at);
    for (int i = 0; i < n; i++) cycle(1'b1, 4'($urandom), i == last_at, i == fs_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic advance();
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic full_line_and_advance();
    send_line(256, 255, -1);
    idle(2);
    advance();
  endtask

  task automatic test_reset();
    apply_reset();
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_full_line();
    int ld0;
    ld0 = ld_seen;
    send_line(256, 255, -1);
    idle(4);
    n_cmp++;
    if (ld_seen - ld0 != 1) begin
      n_err++;
      $display("FAIL full_line_done_count: got %0d want 1", ld_seen - ld0);
    end
    advance();
    n_cmp++;
    if (oldest_fft_idx !== 6'd1) begin
      n_err++;
      $display("FAIL full_line_advance: got %0d want 1", oldest_fft_idx);
    end
  endtask

  task automatic test_short_line();
    int ld0;
    ld0 = ld_seen;
    send_line(101, 100, -1);
    idle(1);
    n_cmp++;
    if (sync_err !== 1'b1 || ld_seen != ld0 || oldest_fft_idx !== 6'd1) begin
      n_err++;
      $display("FAIL short_line: got err=%b done=%0d idx=%0d want err=1 done=0 idx=1",
               sync_err, ld_seen - ld0, oldest_fft_idx);
    end
    full_line_and_advance();
    n_cmp++;
    if (oldest_fft_idx !== 6'd2) begin
      n_err++;
      $display("FAIL short_line_recover: got %0d want 2", oldest_fft_idx);
    end
  endtask

  task automatic test_frame_same_cycle();
    send_line(256, 255, 255);
    idle(10);
    n_cmp++;
    if (oldest_fft_idx !== 6'd2) begin
      n_err++;
      $display("FAIL frame_with_last_beat: got %0d want 2", oldest_fft_idx);
    end
    advance();
    idle(3);
    n_cmp++;
    if (oldest_fft_idx !== 6'd3) begin
      n_err++;
      $display("FAIL frame_after_hold: got %0d want 3", oldest_fft_idx);
    end
  endtask

  task automatic test_stall();
    int  acc;
    int  i;
    bit  v;
    acc = 0;
    i = 0;
    while (acc < 256) begin
      v = 1'($urandom);
      cycle(v, 4'($urandom), v && acc == 255, (i % 37) == 5);
      if (v) acc++;
      i++;
    end
    idle(2);
    n_cmp++;
    if (oldest_fft_idx !== 6'd3) begin
      n_err++;
      $display("FAIL stall_no_advance: got %0d want 3", oldest_fft_idx);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    while (m_slot != 7) full_line_and_advance();
    send_line(60, -1, -1);
    apply_reset();
    send_line(256, 255, -1);
    idle(2);
    n_cmp++;
    if (oldest_fft_idx !== 6'd0) begin
      n_err++;
      $display("FAIL reset_mid_slot: got %0d want 0", oldest_fft_idx);
    end
    advance();
  endtask

  task automatic test_ring_wrap();
    while (m_slot != 25) full_line_and_advance();
    full_line_and_advance();
    while (m_slot != 49) full_line_and_advance();
    full_line_and_advance();
    n_cmp++;
    if (oldest_fft_idx !== 6'd0) begin
      n_err++;
      $display("FAIL ring_wrap: got %0d want 0", oldest_fft_idx);
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short_line();
    test_frame_same_cycle();
    test_stall();
    test_reset_mid();
    test_ring_wrap();
    idle(2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
